// File: rtl/key_press_classifier_pkg.sv
// Shared definitions for the key press classifier and its millisecond timebase.
package key_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      WAIT2,
      PRESS2,
      HOLD
   } key_state_t;

   // Clock cycles per millisecond for a clock given in MHz (MS_DIV).
   function automatic int ms_div_of(input int freq_mhz);
      return freq_mhz * 1000;
   endfunction

   // Prescaler width; a divider of 1 still needs one bit of state.
   function automatic int pre_w_of(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/key_press_classifier_ms_tick_gen.sv
// Millisecond prescaler: counts 0..DIV-1 and flags the terminal count.
// i_clr restarts the count so a timeout can be measured from an arbitrary cycle.
module ms_tick_gen
   import key_pkg::*;
#(
   parameter int DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_ms_tick
);

   localparam int W = pre_w_of(DIV);
   localparam logic [W-1:0] TERM = W'(DIV - 1);

   logic [W-1:0] r_pre;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_pre <= '0;
      end else if (r_pre == TERM) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + W'(1);
      end
   end

   assign o_ms_tick = (r_pre == TERM);

endmodule

// File: rtl/key_press_classifier.sv
// Classifies debounced key gestures into short press, long press and double click.
// Define KEY_AUTO_REPEAT_EN to add periodic key_repeat pulses while a long press is held.
module key_press_classifier
   import key_pkg::*;
#(
   parameter int FREQ      = 100,
   parameter int LONG_MS   = 1000,
   parameter int DOUBLE_MS = 300,
   parameter int REPEAT_MS = 200,
   parameter int MS_W      = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic key_negedge,
   input  logic key_posedge,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic key_repeat,
   output logic busy
);

   localparam int MS_DIV = ms_div_of(FREQ);
   localparam logic [MS_W-1:0] LONG_C   = MS_W'(LONG_MS);
   localparam logic [MS_W-1:0] DOUBLE_C = MS_W'(DOUBLE_MS);

   // Every timeout constant has to be reachable by the saturating counter.
   if ((LONG_MS >= 2**MS_W) || (DOUBLE_MS >= 2**MS_W) || (REPEAT_MS >= 2**MS_W)) begin : g_bad_cfg
      $error("key_press_classifier: timeout constant does not fit in MS_W bits");
   end

   key_state_t      r_state;
   logic [MS_W-1:0] r_ms_cnt;
   logic            r_short;
   logic            r_long;
   logic            r_double;
   logic            r_busy;

   logic w_ms_tick;
   logic w_neg;
   logic w_pos;
   logic w_go_press1;
   logic w_long_hit;
   logic w_go_wait2;
   logic w_short_hit;
   logic w_go_press2;
   logic w_double_hit;
   logic w_hold_rel;
   logic w_repeat_hit;
   logic w_clr;

   ms_tick_gen #(
      .DIV(MS_DIV)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_clr),
      .o_ms_tick(w_ms_tick)
   );

   // A release always wins over a press arriving in the same cycle.
   assign w_pos = key_posedge;
   assign w_neg = key_negedge & ~key_posedge;

   always_comb begin
      w_go_press1  = (r_state == IDLE) && w_neg;
      w_long_hit   = (r_state == PRESS1) && (r_ms_cnt == LONG_C);
      w_go_wait2   = (r_state == PRESS1) && w_pos && !w_long_hit;
      w_short_hit  = (r_state == WAIT2) && (r_ms_cnt == DOUBLE_C);
      w_go_press2  = (r_state == WAIT2) && w_neg && !w_short_hit;
      w_double_hit = (r_state == PRESS2) && w_pos;
      w_hold_rel   = (r_state == HOLD) && w_pos;
`ifdef KEY_AUTO_REPEAT_EN
      w_repeat_hit = (r_state == HOLD) && !w_pos && (r_ms_cnt == MS_W'(REPEAT_MS));
`else
      w_repeat_hit = 1'b0;
`endif
      w_clr = w_go_press1 | w_long_hit | w_go_wait2 | w_short_hit
            | w_go_press2 | w_double_hit | w_hold_rel | w_repeat_hit;
   end

   // Elapsed milliseconds since the last gesture step; restarts with the prescaler.
   always_ff @(posedge clk) begin
      if (rst || w_clr) begin
         r_ms_cnt <= '0;
      end else if (w_ms_tick && (r_ms_cnt != '1)) begin
         r_ms_cnt <= r_ms_cnt + MS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_short  <= 1'b0;
         r_long   <= 1'b0;
         r_double <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_short  <= 1'b0;
         r_long   <= 1'b0;
         r_double <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_go_press1) begin
                  r_state <= PRESS1;
                  r_busy  <= 1'b1;
               end
            end
            PRESS1: begin
               if (w_long_hit) begin
                  r_long  <= 1'b1;
                  r_state <= HOLD;
               end else if (w_go_wait2) begin
                  r_state <= WAIT2;
               end
            end
            WAIT2: begin
               if (w_short_hit) begin
                  r_short <= 1'b1;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_go_press2) begin
                  r_state <= PRESS2;
               end
            end
            PRESS2: begin
               if (w_double_hit) begin
                  r_double <= 1'b1;
                  r_state  <= IDLE;
                  r_busy   <= 1'b0;
               end
            end
            HOLD: begin
               if (w_hold_rel) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef KEY_AUTO_REPEAT_EN
   logic r_repeat;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_repeat <= 1'b0;
      end else begin
         r_repeat <= w_repeat_hit;
      end
   end

   assign key_repeat = r_repeat;
`else
   assign key_repeat = 1'b0;
`endif

   assign short_press  = r_short;
   assign long_press   = r_long;
   assign double_click = r_double;
   assign busy         = r_busy;

endmodule

// File: doc/key_press_classifier.md
Name: key_press_classifier

Overview:
- Sits directly downstream of the key debouncer and consumes its registered one-cycle edge pulses.
- Classifies each user gesture as a short press, a long press or a double click, and emits one single-cycle pulse per gesture to the control logic.
- With AUTO_REPEAT_EN, also emits periodic repeat pulses while a long press is held.
- Key is active-low: a debounced negedge means press, a posedge means release.

Parameters:
- FREQ, 100, clock frequency in MHz.
- LONG_MS, 1000, hold time in ms that qualifies a long press.
- DOUBLE_MS, 300, maximum release-to-second-press gap in ms for a double click.
- REPEAT_MS, 200, auto-repeat period in ms (used only with AUTO_REPEAT_EN).
- MS_W, 16, width of the millisecond counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- key_negedge  in  1  one-cycle press pulse from the debouncer.
- key_posedge  in  1  one-cycle release pulse from the debouncer.
- short_press  out  1  one-cycle pulse: single short press completed.
- long_press  out  1  one-cycle pulse: hold reached LONG_MS.
- double_click  out  1  one-cycle pulse: second press released.
- key_repeat  out  1  one-cycle auto-repeat pulse (tied 0 without the macro).
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: one clock and one reset only; rst is synchronous and active-high. On rst, state = IDLE, prescaler = 0, ms_cnt = 0, and all outputs = 0. An rst asserted mid-gesture aborts it with no pulse emitted.
- Timebase:
  - The prescaler counts 0..FREQ*1000-1; ms_tick is asserted at the terminal count.
  - ms_cnt increments on ms_tick and saturates at 2^MS_W-1.
  - Every state transition clears both the prescaler and ms_cnt in the same cycle, so all timeouts are measured from the triggering edge.
- Output timing: all outputs are registered. Each pulse is high for exactly the one cycle after the cycle in which its condition is detected.
- Simultaneous edges: if key_negedge and key_posedge are high in the same cycle, key_posedge wins and key_negedge is ignored.
- States:
  - IDLE:
    - key_negedge -> PRESS1.
    - key_posedge is ignored.
  - PRESS1:
    - key_posedge with ms_cnt < LONG_MS -> WAIT2.
    - ms_cnt == LONG_MS -> pulse long_press -> HOLD.
  - WAIT2:
    - key_negedge with ms_cnt < DOUBLE_MS -> PRESS2.
    - ms_cnt == DOUBLE_MS -> pulse short_press -> IDLE.
  - PRESS2:
    - key_posedge -> pulse double_click -> IDLE.
    - The timer is ignored: a long second press still yields double_click on release, never long_press.
  - HOLD:
    - key_posedge -> IDLE; no release pulse.
    - key_negedge is ignored.
- Boundaries:
  - A release in the same cycle that ms_cnt reaches LONG_MS gives long_press priority. The FSM goes to HOLD and that key_posedge is dropped.
  - A press in the same cycle that ms_cnt reaches DOUBLE_MS gives the timeout priority. short_press fires, the FSM goes to IDLE, and that key_negedge is dropped.
- Latency: short_press is reported DOUBLE_MS after release, because a possible double click must be ruled out first.
- Pulses are mutually exclusive: at most one output pulse per cycle.
- busy is a registered copy of (state != IDLE).

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined:
  - In HOLD, when ms_cnt == REPEAT_MS, pulse key_repeat, then clear ms_cnt and the prescaler.
  - The first repeat arrives REPEAT_MS after long_press, then one every REPEAT_MS until release.
  - A release in the same cycle as a repeat match suppresses that repeat.
- Undefined:
  - key_repeat is tied to 0 and the HOLD timer compare logic is absent.
  - The port list is unchanged.

Decomposition:
- Shared package key_pkg holds:
  - the state enum (IDLE, PRESS1, WAIT2, PRESS2, HOLD);
  - the derived constant MS_DIV = FREQ*1000;
  - the prescaler width from $clog2(MS_DIV).
- One sub-module, ms_tick_gen: prescaler with a synchronous clear input and a one-cycle ms_tick output. The same module is reused by other timed blocks.

Test Plan:
All scenarios use FREQ=1, LONG_MS=20, DOUBLE_MS=10, REPEAT_MS=5, so 1 ms = 1000 cycles.
1. negedge, posedge 5 ms later, nothing further -> short_press exactly 10000 cycles after the posedge plus one cycle; no other pulse.
2. negedge held 25 ms, then posedge -> one long_press 20000 cycles after the negedge plus one cycle; no short_press on release.
3. negedge, posedge at 3 ms, negedge 4 ms later, posedge 2 ms later -> one double_click the cycle after the second posedge; no short_press.
4. Second negedge in the exact cycle ms_cnt reaches 10 in WAIT2 -> short_press fires, FSM returns to IDLE, and the next posedge is ignored.
5. With KEY_AUTO_REPEAT_EN, hold 36 ms -> long_press at 20 ms, key_repeat at 25, 30 and 35 ms, then none after release.
6. rst pulsed high for one cycle while in PRESS1 at 15 ms -> all outputs 0, busy 0 next cycle; holding 10 ms more gives no long_press.
